alu_pipe: RTL and testbench

Parametrised, registered successor to the single-cycle execute-stage ALU: a WIDTH-bit ALU with valid/ready handshakes on input and output, an extended operation set (shifts, set-less-than) and an optional iterative shift-add multiplier. It sits in the EX stage of the pipelined CPU, between the operand-forwarding muxes and the EX/MEM register. The ready/valid handshake lets it stall the pipeline during multi-cycle operations.

---
 rtl/alu_pipe.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: registered EX-stage ALU with valid/ready handshakes on both sides.
// Optional iterative shift-add multiplier (op 10) enabled by defining ALU_MUL_EN;
// without it op 10 is reported as an illegal single-cycle operation.
module alu_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             illegal
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_e;

  // single-cycle datapath
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_ill;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [SHW-1:0]   shamt;

  // output registers
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             illegal_q, illegal_d;

  logic accept;
  logic handshake;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] mul_sum;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
`else
  assign in_ready = !out_valid_q || out_ready;
`endif

  assign accept    = in_valid && in_ready;
  assign handshake = out_valid_q && out_ready;
  assign shamt     = b[SHW-1:0];

  // Combinational result and flags for every single-cycle op code.
  always_comb begin
    add_ext = {1'b0, a} + {1'b0, b};
    sub_ext = {1'b0, a} - {1'b0, b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_ext[WIDTH-1:0];
        alu_c   = !sub_ext[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: alu_res = WIDTH'(a < b);
      // op 10 lands here too; with the multiplier built it never reaches this path
      default: alu_ill = 1'b1;
    endcase
  end

  // Next-state logic: result registration, handshake bookkeeping, multiplier steps.
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;
`ifdef ALU_MUL_EN
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (alu_op == OP_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            carry_d     = alu_c;
            ovf_d       = alu_v;
            illegal_d   = alu_ill;
            out_valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          result_d    = mul_sum;
          zero_d      = (mul_sum == '0);
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (handshake) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`else
    if (accept) begin
      result_d    = alu_res;
      zero_d      = (alu_res == '0);
      carry_d     = alu_c;
      ovf_d       = alu_v;
      illegal_d   = alu_ill;
      out_valid_d = 1'b1;
    end
`endif
  end

  // Output and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef ALU_MUL_EN
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
`ifdef ALU_MUL_EN
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=32): directed vectors with literal expectations plus
// a queue-based reference model checked on every cycle.
module tb_alu_pipe;
  localparam int W = 32;
`ifdef ALU_MUL_EN
  localparam int MUL_LAT = W;
`else
  localparam int MUL_LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   alu_op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, carry, ovf, illegal;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] r;
    logic         z, c, v, i;
    bit           mul;
    int           rdy;
  } exp_t;

  exp_t q[$];
  bit   mul_out = 1'b0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .ovf(ovf), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Reference model: value-level arithmetic, no knowledge of the datapath
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] op);
    exp_t   e;
    longint sx, sy, sr;
    longint ux, uy;
    logic [4:0] sh;
    e.r = '0; e.z = 0; e.c = 0; e.v = 0; e.i = 0; e.mul = 0; e.rdy = 0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    sh = y[4:0];
    case (op)
      4'd0: begin
        e.r = x + y;
        e.c = (ux + uy) > 64'h0000_0000_FFFF_FFFF;
        sr  = sx + sy;
        e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd1: begin
        e.r = x - y;
        e.c = (ux >= uy);
        sr  = sx - sy;
        e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd2: e.r = x & y;
      4'd3: e.r = x | y;
      4'd4: e.r = x ^ y;
      4'd5: e.r = x << sh;
      4'd6: e.r = x >> sh;
      4'd7: e.r = W'(sx >>> sh);
      4'd8: e.r = (sx < sy) ? 32'd1 : 32'd0;
      4'd9: e.r = (ux < uy) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
      4'd10: begin e.r = W'(ux * uy); e.mul = 1; end
`endif
      default: e.i = 1;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // Every-cycle comparison of the DUT against the model queue
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mul_out = 0;
    end else begin
      bit ev;
      bit eir;
      ev  = (q.size() > 0) && (cyc >= q[0].rdy);
      eir = !mul_out && (!ev || out_ready);
      chk("mon.out_valid", out_valid, ev);
      chk("mon.in_ready", in_ready, eir);
      if (ev) begin
        chk("mon.result", result, q[0].r);
        chk("mon.flags", {zero, carry, ovf, illegal}, {q[0].z, q[0].c, q[0].v, q[0].i});
        if (out_ready) begin
          if (q[0].mul) mul_out = 0;
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e = model(a, b, alu_op);
        e.rdy = cyc + 1 + (e.mul ? MUL_LAT : 0);
        q.push_back(e);
        if (e.mul) mul_out = 1;
      end
    end
  end

  // Issue one op with out_ready=1; optionally check literal result, flags {z,c,v,i}, latency
  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb2,
                        input logic [3:0] top, input bit lit, input logic [W-1:0] er,
                        input logic [3:0] ef, input int elat);
    int n;
    bit busy_rdy;
    a = ta; b = tb2; alu_op = top; in_valid = 1; out_ready = 1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    chk({nm, ".accept"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    n = 0; busy_rdy = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      if (in_ready) busy_rdy = 1;
      n++;
      @(negedge clk);
    end
    if (lit) begin
      chk({nm, ".valid"}, out_valid, 1);
      chk({nm, ".lat"}, n, elat);
      chk({nm, ".result"}, result, er);
      chk({nm, ".flags"}, {zero, carry, ovf, illegal}, ef);
      if (elat > 0) chk({nm, ".busy"}, busy_rdy, 0);
    end
    @(posedge clk); #1;
  endtask

  logic [W-1:0] ga[3] = '{32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFFF};
  logic [W-1:0] gb[3] = '{32'h0000_0013, 32'h7FFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset held for two cycles
    @(negedge clk); @(negedge clk);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.result", result, 0);
    chk("rst.flags", {zero, carry, ovf, illegal}, 4'b0000);
    chk("rst.in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1;

    run_op("add_ovf",  32'h7FFF_FFFF, 32'h1,          4'd0,  1, 32'h8000_0000, 4'b0010, 0);
    run_op("sub_eq",   32'd5,         32'd5,          4'd1,  1, 32'h0,         4'b1100, 0);
    run_op("sub_ovf",  32'h8000_0000, 32'h1,          4'd1,  1, 32'h7FFF_FFFF, 4'b0110, 0);
    run_op("sub_brw",  32'd1,         32'd2,          4'd1,  1, 32'hFFFF_FFFF, 4'b0000, 0);
    run_op("add_wrap", 32'hFFFF_FFFF, 32'h1,          4'd0,  1, 32'h0,         4'b1100, 0);
    run_op("and",      32'hF0F0_F0F0, 32'hFF00_FF00,  4'd2,  1, 32'hF000_F000, 4'b0000, 0);
    run_op("or",       32'hF0F0_F0F0, 32'hFF00_FF00,  4'd3,  1, 32'hFFF0_FFF0, 4'b0000, 0);
    run_op("xor",      32'hF0F0_F0F0, 32'hFF00_FF00,  4'd4,  1, 32'h0FF0_0FF0, 4'b0000, 0);
    run_op("sll",      32'd3,         32'h21,         4'd5,  1, 32'd6,         4'b0000, 0);
    run_op("srl",      32'h8000_0000, 32'd4,          4'd6,  1, 32'h0800_0000, 4'b0000, 0);
    run_op("sra",      32'h8000_0000, 32'd4,          4'd7,  1, 32'hF800_0000, 4'b0000, 0);
    run_op("slt",      32'hFFFF_FFFF, 32'd1,          4'd8,  1, 32'd1,         4'b0000, 0);
    run_op("sltu",     32'hFFFF_FFFF, 32'd1,          4'd9,  1, 32'd0,         4'b1000, 0);
    run_op("ill13",    32'h1234_5678, 32'h9,          4'd13, 1, 32'd0,         4'b1001, 0);
`ifdef ALU_MUL_EN
    run_op("mul",      32'h0000_FFFF, 32'h0001_0001,  4'd10, 1, 32'hFFFF_FFFF, 4'b0000, 32);
    run_op("mul_zero", 32'd0,         32'd5,          4'd10, 1, 32'd0,         4'b1000, 32);
`else
    run_op("mul_ill",  32'h0000_FFFF, 32'h0001_0001,  4'd10, 1, 32'd0,         4'b1001, 0);
`endif

    // every op code over a few operand pairs, model-checked only
    for (int op = 0; op < 16; op++)
      for (int k = 0; k < 3; k++)
        run_op("gen", ga[k], gb[k], 4'(op), 0, '0, 4'b0000, 0);

    // throughput: four back-to-back ADDs
    alu_op = 4'd0; out_ready = 1; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      a = 32'(10 * i + 1); b = 32'd2;
      @(negedge clk);
      chk("tput.in_ready", in_ready, 1);
      if (i > 0) begin
        chk("tput.valid", out_valid, 1);
        chk("tput.result", result, 32'(10 * i - 7));
      end
      @(posedge clk); #1;
    end
    // backpressure: result holds, nothing accepted
    a = 32'd100; b = 32'd5; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold.valid", out_valid, 1);
      chk("hold.result", result, 32'd33);
      chk("hold.in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    // consume and accept on the same edge
    out_ready = 1;
    @(negedge clk);
    chk("swap.in_ready", in_ready, 1);
    chk("swap.old", result, 32'd33);
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    chk("swap.valid", out_valid, 1);
    chk("swap.result", result, 32'd105);
    @(posedge clk); #1;

    // reset while a result is held
    out_ready = 0; alu_op = 4'd0; a = 32'd1; b = 32'd1; in_valid = 1;
    @(negedge clk);
    chk("rsth.in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    chk("rsth.result", result, 32'd2);
    @(posedge clk); #1;
    rst_n = 0;
    @(negedge clk);
    chk("rsth.out_valid", out_valid, 0);
    chk("rsth.cleared", result, 0);
    chk("rsth.in_ready", in_ready, 1);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1; out_ready = 1;

`ifdef ALU_MUL_EN
    // reset in the middle of a multiply: result is abandoned
    a = 32'd7; b = 32'd9; alu_op = 4'd10; in_valid = 1;
    @(negedge clk);
    chk("mulrst.accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    repeat (10) @(posedge clk);
    #1 rst_n = 0;
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("mulrst.out_valid", out_valid, 0);
      chk("mulrst.in_ready", in_ready, 1);
    end
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drain.queue", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
